// File: rtl/bcd_score_counter_n.sv
// Multi-digit BCD up/down score counter with debounced-style key auto-repeat,
// clear/load override, saturate or wrap at the limits, and a change pulse.
module bcd_score_counter_n #(
  parameter int unsigned P_DIGITS   = 2,
  parameter int unsigned P_WRAP     = 0,
  parameter int unsigned P_HOLD_CYC = 50000000,
  parameter int unsigned P_RPT_CYC  = 10000000
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_mode_sw,
  input  logic                  I_count_key,
  input  logic                  I_clear_key,
  input  logic                  I_step10,
  input  logic                  I_load,
  input  logic [4*P_DIGITS-1:0] I_load_bcd,
  output logic [4*P_DIGITS-1:0] O_bcd,
  output logic                  O_mode,
  output logic                  O_at_max,
  output logic                  O_at_min,
  output logic                  O_event
);

  localparam int unsigned W       = 4 * P_DIGITS;
  localparam int unsigned CntMax  = (P_HOLD_CYC > P_RPT_CYC) ? P_HOLD_CYC : P_RPT_CYC;
  localparam int unsigned CntW    = (CntMax > 2) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(P_HOLD_CYC - 1);
  localparam logic [CntW-1:0] RptLast  = CntW'(P_RPT_CYC - 1);
  localparam logic [W-1:0]    AllNines = {P_DIGITS{4'h9}};

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mode_sw_q, count_key_q;
  logic            mode_q, mode_d;
  logic [W-1:0]    bcd_q, bcd_d;
  logic            event_q;
  logic            key_rise, step;

  assign key_rise = I_count_key & ~count_key_q;

  // Repeat FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (key_rise) begin
          state_d = StHold;
          step    = 1'b1;
        end
      end
      StHold: begin
        if (!I_count_key) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StRepeat;
          step    = 1'b1;
          cnt_d   = '0;
        end
      end
      StRepeat: begin
        if (!I_count_key) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == RptLast) begin
          step  = 1'b1;
          cnt_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign mode_d = mode_q ^ (I_mode_sw & ~mode_sw_q);

  // BCD increment/decrement starting at units or tens, ripple across digits
  logic [W-1:0] step_res, load_val;
  logic         carry;
  logic [3:0]   dig;
  int           lsd;

  always_comb begin
    step_res = bcd_q;
    carry    = 1'b0;
    dig      = '0;
    lsd      = (I_step10 && P_DIGITS > 1) ? 1 : 0;
    for (int i = 0; i < int'(P_DIGITS); i++) begin
      dig = bcd_q[4*i +: 4];
      if (i == lsd) carry = 1'b1;
      if (carry) begin
        if (!mode_q) begin
          if (dig == 4'd9) begin
            step_res[4*i +: 4] = 4'd0;
          end else begin
            step_res[4*i +: 4] = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            step_res[4*i +: 4] = 4'd9;
          end else begin
            step_res[4*i +: 4] = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    // Carry/borrow out of the top digit means the limit was crossed
    if (carry && P_WRAP == 0) begin
      step_res = mode_q ? '0 : AllNines;
    end
  end

  always_comb begin
    load_val = '0;
    for (int i = 0; i < int'(P_DIGITS); i++) begin
      load_val[4*i +: 4] = (I_load_bcd[4*i +: 4] > 4'd9) ? 4'd9 : I_load_bcd[4*i +: 4];
    end
  end

  always_comb begin
    bcd_d = bcd_q;
    if (I_clear_key) begin
      bcd_d = '0;
    end else if (I_load) begin
      bcd_d = load_val;
    end else if (step) begin
      bcd_d = step_res;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mode_sw_q   <= 1'b0;
      count_key_q <= 1'b0;
      mode_q      <= 1'b0;
      bcd_q       <= '0;
      event_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_sw_q   <= I_mode_sw;
      count_key_q <= I_count_key;
      mode_q      <= mode_d;
      bcd_q       <= bcd_d;
      event_q     <= (bcd_d != bcd_q);
    end
  end

  assign O_bcd    = bcd_q;
  assign O_mode   = mode_q;
  assign O_event  = event_q;
  assign O_at_max = (bcd_q == AllNines);
  assign O_at_min = (bcd_q == '0);

endmodule

// File: tb/tb_bcd_score_counter_n.sv
// Scoreboarded bench: saturating and wrapping counters share one stimulus stream;
// each O_event pulse is matched against the next queued expected value.
module tb_bcd_score_counter_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_sw = 1'b0, count_key = 1'b0, clear_key = 1'b0, step10 = 1'b0, load = 1'b0;
  logic [7:0] load_bcd = 8'h00;

  logic [7:0] bcd_s, bcd_w;
  logic       mode_s, mode_w, max_s, max_w, min_s, min_w, ev_s, ev_w;

  logic [7:0] q_s[$];
  logic [7:0] q_w[$];
  logic [7:0] exp_s = 8'h00, exp_w = 8'h00;
  int         n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  bcd_score_counter_n #(.P_DIGITS(2), .P_WRAP(0), .P_HOLD_CYC(4), .P_RPT_CYC(2)) u_sat (
    .I_clk(clk), .I_rst_n(rst_n), .I_mode_sw(mode_sw), .I_count_key(count_key),
    .I_clear_key(clear_key), .I_step10(step10), .I_load(load), .I_load_bcd(load_bcd),
    .O_bcd(bcd_s), .O_mode(mode_s), .O_at_max(max_s), .O_at_min(min_s), .O_event(ev_s)
  );

  bcd_score_counter_n #(.P_DIGITS(2), .P_WRAP(1), .P_HOLD_CYC(4), .P_RPT_CYC(2)) u_wrap (
    .I_clk(clk), .I_rst_n(rst_n), .I_mode_sw(mode_sw), .I_count_key(count_key),
    .I_clear_key(clear_key), .I_step10(step10), .I_load(load), .I_load_bcd(load_bcd),
    .O_bcd(bcd_w), .O_mode(mode_w), .O_at_max(max_w), .O_at_min(min_w), .O_event(ev_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue an expected value only when it differs from the current one
  task automatic set_exp(input logic [7:0] vs, input logic [7:0] vw);
    if (vs != exp_s) q_s.push_back(vs);
    if (vw != exp_w) q_w.push_back(vw);
    exp_s = vs;
    exp_w = vw;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press();
    count_key = 1'b1;
    tick();
    count_key = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_bcd = v;
    tick();
    load = 1'b0;
    tick();
  endtask

  task automatic toggle_mode();
    mode_sw = 1'b1;
    repeat (3) tick();
    mode_sw = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (ev_s) begin
      if (q_s.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sat_unexpected_event: got bcd=%0h expected no event", bcd_s);
      end else begin
        e = q_s.pop_front();
        chk("sat_event_value", 32'(bcd_s), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (ev_w) begin
      if (q_w.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wrap_unexpected_event: got bcd=%0h expected no event", bcd_w);
      end else begin
        e = q_w.pop_front();
        chk("wrap_event_value", 32'(bcd_w), 32'(e));
      end
    end
  end

  initial begin
    repeat (2) tick();
    chk("reset_bcd", 32'(bcd_s), 32'h00);
    chk("reset_mode", 32'(mode_s), 32'h0);
    chk("reset_event", 32'(ev_s), 32'h0);
    chk("reset_at_min", 32'(min_s), 32'h1);
    chk("reset_at_max", 32'(max_s), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single press from 00
    set_exp(8'h01, 8'h01);
    press();
    chk("single_press_bcd", 32'(bcd_w), 32'h01);
    clear_key = 1'b1;
    set_exp(8'h00, 8'h00);
    tick();
    clear_key = 1'b0;
    tick();

    // Hold 10 cycles: steps at press, +4, +6, +8
    set_exp(8'h01, 8'h01);
    set_exp(8'h02, 8'h02);
    set_exp(8'h03, 8'h03);
    set_exp(8'h04, 8'h04);
    count_key = 1'b1;
    repeat (10) tick();
    count_key = 1'b0;
    repeat (6) tick();
    chk("hold_repeat_bcd", 32'(bcd_s), 32'h04);

    // Limit at the top: saturate vs wrap
    set_exp(8'h97, 8'h97);
    do_load(8'h97);
    step10 = 1'b1;
    set_exp(8'h99, 8'h07);
    press();
    chk("sat_at_max", 32'(max_s), 32'h1);
    chk("wrap_not_at_max", 32'(max_w), 32'h0);
    step10 = 1'b0;
    set_exp(8'h99, 8'h08);
    press();
    chk("sat_held_99", 32'(bcd_s), 32'h99);

    // Limit at the bottom, then up-wrap 99 -> 00
    set_exp(8'h03, 8'h03);
    do_load(8'h03);
    toggle_mode();
    chk("mode_down", 32'(mode_w), 32'h1);
    step10 = 1'b1;
    set_exp(8'h00, 8'h93);
    press();
    step10 = 1'b0;
    chk("sat_at_min", 32'(min_s), 32'h1);
    set_exp(8'h99, 8'h99);
    do_load(8'h99);
    toggle_mode();
    chk("mode_up", 32'(mode_s), 32'h0);
    set_exp(8'h99, 8'h00);
    press();
    chk("wrap_at_min", 32'(min_w), 32'h1);
    chk("sat_at_max_again", 32'(max_s), 32'h1);

    // Priority clear > load > step, and digit clamping
    set_exp(8'h42, 8'h42);
    do_load(8'h42);
    clear_key = 1'b1;
    load      = 1'b1;
    load_bcd  = 8'h55;
    count_key = 1'b1;
    set_exp(8'h00, 8'h00);
    tick();
    clear_key = 1'b0;
    load      = 1'b0;
    count_key = 1'b0;
    repeat (2) tick();
    chk("priority_bcd", 32'(bcd_s), 32'h00);
    set_exp(8'h99, 8'h99);
    do_load(8'hFA);
    chk("clamp_bcd", 32'(bcd_w), 32'h99);
    do_load(8'h99);
    clear_key = 1'b1;
    set_exp(8'h00, 8'h00);
    repeat (3) tick();
    clear_key = 1'b0;
    tick();

    // Toggle on the same edge as a step: step still counts up
    set_exp(8'h40, 8'h40);
    do_load(8'h40);
    mode_sw   = 1'b1;
    count_key = 1'b1;
    set_exp(8'h41, 8'h41);
    tick();
    mode_sw   = 1'b0;
    count_key = 1'b0;
    repeat (2) tick();
    chk("same_edge_mode", 32'(mode_s), 32'h1);
    set_exp(8'h40, 8'h40);
    press();
    set_exp(8'h39, 8'h39);
    press();
    chk("borrow_bcd", 32'(bcd_s), 32'h39);

    // Reset during repeat, key still held at release
    do_load(8'h39);
    set_exp(8'h38, 8'h38);
    set_exp(8'h37, 8'h37);
    count_key = 1'b1;
    repeat (5) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_bcd", 32'(bcd_s), 32'h00);
    chk("async_reset_mode", 32'(mode_w), 32'h0);
    chk("async_reset_event", 32'(ev_w), 32'h0);
    exp_s = 8'h00;
    exp_w = 8'h00;
    repeat (2) tick();
    set_exp(8'h01, 8'h01);
    rst_n = 1'b1;
    tick();
    count_key = 1'b0;
    repeat (3) tick();
    chk("post_reset_step_bcd", 32'(bcd_s), 32'h01);

    repeat (4) tick();
    chk("sat_queue_drained", 32'(q_s.size()), 32'h0);
    chk("wrap_queue_drained", 32'(q_w.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
